// File: rtl/iecdrv_clk_pkg.sv
// Shared types and elaboration helpers for the drive-CPU clock-enable sequencer.
package iecdrv_clk_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    // Width of a speed index; one speed still needs a 1-bit port.
    function automatic int speed_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Accumulator width: holds acc + increment (< 2*clk_hz) without overflow.
    function automatic int acc_w(input int clk_hz);
        return $clog2(clk_hz) + 1;
    endfunction

endpackage

// File: rtl/iecdrv_frac_div.sv
// Fractional divider: half_tick pulses at OUT_HZ average rate with at most one clk of jitter.
// half_tick is combinational from the accumulator; there is no backpressure.
module iecdrv_frac_div
    import iecdrv_clk_pkg::*;
#(
    parameter int CLK_HZ = 32_000_000,
    parameter int OUT_HZ = 4_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic half_tick
);

    localparam int ACC_W = acc_w(CLK_HZ);
    localparam logic [ACC_W-1:0] INC  = ACC_W'(OUT_HZ);
    localparam logic [ACC_W-1:0] MODV = ACC_W'(CLK_HZ);

    if (OUT_HZ > CLK_HZ) begin : g_bad_rate
        $error("iecdrv_frac_div: OUT_HZ (2*BASE_HZ) exceeds CLK_HZ");
    end

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] acc_sum;

    always_comb begin
        acc_sum   = acc_q + INC;
        half_tick = (acc_sum >= MODV);
        acc_d     = half_tick ? (acc_sum - MODV) : acc_sum;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/iecdrv_cpu_clkctl.sv
// Drive-CPU clock-enable sequencer: per-speed phase-2 strobes, selected ena_r/ena_f, halt on speed switch.
// All outputs registered; stall only masks enables. IECDRV_CLKCTL_CYCCNT_EN adds the 32-bit ena_f counter.
module iecdrv_cpu_clkctl
    import iecdrv_clk_pkg::*;
#(
    parameter int CLK_HZ      = 32_000_000,
    parameter int BASE_HZ     = 2_000_000,
    parameter int NUM_SPEEDS  = 2,
    parameter int HALT_CYC    = 2,
    parameter int RESET_SPEED = 1,
    localparam int SW         = speed_w(NUM_SPEEDS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SW-1:0]         speed_req,
    input  logic                  stall,
    output logic [NUM_SPEEDS-1:0] ph2_r,
    output logic [NUM_SPEEDS-1:0] ph2_f,
    output logic                  ena_r,
    output logic                  ena_f,
    output logic                  halt,
    output logic [SW-1:0]         cur_speed,
    output logic [31:0]           cyc_cnt
);

    localparam int NP = 1 << SW;
    localparam int HW = (HALT_CYC < 2) ? 1 : $clog2(HALT_CYC + 1);

    function automatic logic [NUM_SPEEDS-1:0] low_mask(input int k);
        return NUM_SPEEDS'((1 << (k + 1)) - 1);
    endfunction

    logic half_tick;

    iecdrv_frac_div #(
        .CLK_HZ (CLK_HZ),
        .OUT_HZ (2 * BASE_HZ)
    ) u_frac_div (
        .clk       (clk),
        .reset     (reset),
        .half_tick (half_tick)
    );

    logic [NUM_SPEEDS-1:0] div_cnt_q, div_cnt_d, cnt_inc;
    logic [NUM_SPEEDS-1:0] ph2_r_q, ph2_r_d, ph2_f_q, ph2_f_d;

    // Speed k: rising edge when the low k+1 bits reach the half-way point, falling at wrap.
    always_comb begin
        cnt_inc   = div_cnt_q + NUM_SPEEDS'(1);
        div_cnt_d = half_tick ? cnt_inc : div_cnt_q;
        ph2_r_d   = '0;
        ph2_f_d   = '0;
        for (int k = 0; k < NUM_SPEEDS; k++) begin
            ph2_r_d[k] = half_tick && ((cnt_inc & low_mask(k)) == NUM_SPEEDS'(1 << k));
            ph2_f_d[k] = half_tick && ((cnt_inc & low_mask(k)) == '0);
        end
    end

    state_t          state_q, state_d;
    logic [SW-1:0]   cur_q, cur_d, nxt_q, nxt_d, req_c;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic            ena_r_q, ena_r_d, ena_f_q, ena_f_d;
    logic [NP-1:0]   r_sel, f_sel;

    always_comb begin
        r_sel   = NP'(ph2_r_q);
        f_sel   = NP'(ph2_f_q);
        req_c   = (int'(speed_req) >= NUM_SPEEDS) ? SW'(NUM_SPEEDS - 1) : speed_req;
        state_d = state_q;
        cur_d   = cur_q;
        nxt_d   = nxt_q;
        hcnt_d  = hcnt_q;
        ena_r_d = 1'b0;
        ena_f_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                ena_r_d = r_sel[cur_q] & ~stall;
                ena_f_d = f_sel[cur_q] & ~stall;
                if (r_sel[cur_q] && (req_c != cur_q)) begin
                    nxt_d   = req_c;
                    hcnt_d  = HW'(HALT_CYC);
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                // The last counted edge hands over without its own ena_r; the new speed starts on ph2_f.
                if (r_sel[nxt_q]) begin
                    if (hcnt_q == HW'(1)) begin
                        cur_d   = nxt_q;
                        state_d = ST_RUN;
                    end else begin
                        hcnt_d = hcnt_q - HW'(1);
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q <= '0;
            ph2_r_q   <= '0;
            ph2_f_q   <= '0;
            state_q   <= ST_RUN;
            cur_q     <= SW'(RESET_SPEED);
            nxt_q     <= SW'(RESET_SPEED);
            hcnt_q    <= '0;
            ena_r_q   <= 1'b0;
            ena_f_q   <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            ph2_r_q   <= ph2_r_d;
            ph2_f_q   <= ph2_f_d;
            state_q   <= state_d;
            cur_q     <= cur_d;
            nxt_q     <= nxt_d;
            hcnt_q    <= hcnt_d;
            ena_r_q   <= ena_r_d;
            ena_f_q   <= ena_f_d;
        end
    end

    assign ph2_r     = ph2_r_q;
    assign ph2_f     = ph2_f_q;
    assign ena_r     = ena_r_q;
    assign ena_f     = ena_f_q;
    assign halt      = (state_q == ST_HALT);
    assign cur_speed = cur_q;

`ifdef IECDRV_CLKCTL_CYCCNT_EN
    logic [31:0] cyc_cnt_q, cyc_cnt_d;

    always_comb begin
        cyc_cnt_d = cyc_cnt_q + 32'(ena_f_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_cnt_q <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
        end
    end

    assign cyc_cnt = cyc_cnt_q;
`else
    assign cyc_cnt = '0;
`endif

endmodule
